weight_fetch_unit: RTL and testbench

//  Producer side of the weight FIFO interface feeding the weight control unit.
//  - Streams weight tiles from weight memory as MUL_SIZE rows per tile.
//  - Buffers rows in an internal FIFO and presents them with a valid flag.
//  - The weight control unit pops one row per cycle while loading the systolic array.
//  - Sits between weight memory and the weight control unit / MAC array weight inputs.

---
 rtl/weight_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_weight_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_unit.sv
// Weight fetch unit: streams MUL_SIZE-row weight tiles from weight memory into a
// small first-word-fall-through row FIFO consumed by the weight control unit.
module weight_fetch_unit #(
  parameter int MUL_SIZE   = 32,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          base_addr_i,
  input  logic [7:0]                 num_tiles_i,
  output logic                       mem_rd_en_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic [MUL_SIZE*DATA_W-1:0] mem_rdata_i,
  output logic [MUL_SIZE*DATA_W-1:0] weight_row_o,
  output logic                       weight_fifo_valid_o,
  input  logic                       weight_pop_i,
  output logic                       tile_last_row_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o
);

  localparam int ROW_W = MUL_SIZE * DATA_W;
  localparam int RC_W  = $clog2(MUL_SIZE);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [RC_W-1:0]   row_cntr_q, row_cntr_d;
  logic [7:0]        tile_cntr_q, tile_cntr_d;
  logic [7:0]        num_tiles_q, num_tiles_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              error_q;
  logic              inflight_q, inflight_last_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ROW_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic              fifo_tag [FIFO_DEPTH];

  logic rd_en;
  logic row_last;
  logic tile_last;
  logic credit_ok;
  logic push;
  logic pop_ok;
  logic pop_empty;
  logic final_pop;

  // The running address register equals base + tile*MUL_SIZE + row, wrapping mod 2^ADDR_W.
  assign row_last  = (row_cntr_q == RC_W'(MUL_SIZE - 1));
  assign tile_last = (tile_cntr_q == (num_tiles_q - 8'd1));
  assign credit_ok = ((count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
  assign push      = inflight_q;
  assign pop_ok    = weight_pop_i && (count_q != '0);
  assign pop_empty = weight_pop_i && (count_q == '0);
  // In DRAIN nothing more is coming, so the last buffered row is the final row of the job.
  assign final_pop = pop_ok && (count_q == CNT_W'(1)) && !inflight_q;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    row_cntr_d  = row_cntr_q;
    tile_cntr_d = tile_cntr_q;
    num_tiles_d = num_tiles_q;
    addr_d      = addr_q;
    done_d      = 1'b0;
    rd_en       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (num_tiles_i != 8'd0) begin
            state_d     = S_FETCH;
            num_tiles_d = num_tiles_i;
            addr_d      = base_addr_i;
            row_cntr_d  = '0;
            tile_cntr_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (credit_ok) begin
          rd_en  = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          if (row_last) begin
            row_cntr_d  = '0;
            tile_cntr_d = tile_cntr_q + 8'd1;
            if (tile_last) state_d = S_DRAIN;
          end else begin
            row_cntr_d = row_cntr_q + RC_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (final_pop) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      row_cntr_q      <= '0;
      tile_cntr_q     <= '0;
      num_tiles_q     <= '0;
      addr_q          <= '0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      row_cntr_q      <= row_cntr_d;
      tile_cntr_q     <= tile_cntr_d;
      num_tiles_q     <= num_tiles_d;
      addr_q          <= addr_d;
      done_q          <= done_d;
      error_q         <= error_q | pop_empty;
      inflight_q      <= rd_en;
      inflight_last_q <= row_last;
      count_q         <= count_d;
      if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: the row storage has no reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_rdata_i;
      fifo_tag[wr_ptr_q] <= inflight_last_q;
    end
  end

  assign weight_fifo_valid_o = (count_q != '0);
  assign weight_row_o        = weight_fifo_valid_o ? fifo_mem[rd_ptr_q] : '0;
  assign tile_last_row_o     = weight_fifo_valid_o && fifo_tag[rd_ptr_q];
  assign mem_rd_en_o         = rd_en;
  assign mem_addr_o          = addr_q;
  assign busy_o              = (state_q != S_IDLE);
  assign done_o              = done_q;
  assign error_o             = error_q;

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Directed bench for weight_fetch_unit: a one-cycle-latency memory model answers
// reads; per-scenario tasks compare the streamed rows against expected addresses.
module tb_weight_fetch_unit;

  logic         clk_i;
  logic         rst_ni;
  logic         start_i;
  logic [15:0]  base_addr_i;
  logic [7:0]   num_tiles_i;
  logic         mem_rd_en_o;
  logic [15:0]  mem_addr_o;
  logic [255:0] mem_rdata_i;
  logic [255:0] weight_row_o;
  logic         weight_fifo_valid_o;
  logic         weight_pop_i;
  logic         tile_last_row_o;
  logic         busy_o;
  logic         done_o;
  logic         error_o;

  weight_fetch_unit dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .start_i             (start_i),
    .base_addr_i         (base_addr_i),
    .num_tiles_i         (num_tiles_i),
    .mem_rd_en_o         (mem_rd_en_o),
    .mem_addr_o          (mem_addr_o),
    .mem_rdata_i         (mem_rdata_i),
    .weight_row_o        (weight_row_o),
    .weight_fifo_valid_o (weight_fifo_valid_o),
    .weight_pop_i        (weight_pop_i),
    .tile_last_row_o     (tile_last_row_o),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .error_o             (error_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Distinct content per row address so lost, duplicated or reordered rows show up.
  function automatic logic [255:0] row_of(input logic [15:0] a);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = a ^ {8'(i), 8'(255 - i)};
    return r;
  endfunction

  // Memory model: data for a read seen in cycle c is driven during cycle c+1.
  logic        pending;
  logic [15:0] pend_addr;
  initial begin
    pending     = 1'b0;
    pend_addr   = '0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_rdata_i = pending ? row_of(pend_addr) : {32{8'hEE}};
      pending     = mem_rd_en_o;
      pend_addr   = mem_addr_o;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_reads, n_rows, addr_err, data_err, last_err, n_last, n_done;
  int first_rd, first_vld, last_pop, done_cyc, max_out, start_cyc, reads_hold;
  logic done_busy, hold_rd, hold_vld, err_early, timed_out;
  logic [15:0] exp_addr, exp_row;
  logic [15:0] rd_q [$];

  task automatic init_stats(input logic [15:0] base);
    n_reads = 0; n_rows = 0; addr_err = 0; data_err = 0; last_err = 0;
    n_last = 0; n_done = 0; first_rd = -1; first_vld = -1; last_pop = -1;
    done_cyc = -1; max_out = 0; reads_hold = -1; done_busy = 1'bx;
    hold_rd = 1'bx; hold_vld = 1'bx; err_early = 1'bx;
    exp_addr = base; exp_row = base;
    rd_q.delete();
  endtask

  // One cycle: observe outputs at the falling edge, then drive this cycle's inputs.
  task automatic step(input logic pop, input logic st);
    @(negedge clk_i);
    cyc++;
    if (mem_rd_en_o === 1'b1) begin
      if (first_rd < 0) first_rd = cyc;
      rd_q.push_back(mem_addr_o);
      if (mem_addr_o !== exp_addr) addr_err++;
      exp_addr++;
      n_reads++;
    end
    if (weight_fifo_valid_o === 1'b1 && first_vld < 0) first_vld = cyc;
    if (done_o === 1'b1) begin
      n_done++;
      done_busy = busy_o;
      done_cyc  = cyc;
    end
    if (pop && weight_fifo_valid_o === 1'b1) begin
      if (weight_row_o !== row_of(exp_row)) data_err++;
      if (tile_last_row_o !== ((n_rows % 32) == 31)) last_err++;
      if (tile_last_row_o === 1'b1) n_last++;
      exp_row++;
      n_rows++;
      last_pop = cyc;
    end
    weight_pop_i = pop;
    start_i      = st;
    if (n_reads - n_rows > max_out) max_out = n_reads - n_rows;
  endtask

  // mode 0: pop held 1; mode 1: pop 0 until step `hold`, then 1; mode 2: pop toggles.
  task automatic run_job(input logic [15:0] base, input logic [7:0] tiles,
                         input int mode, input int hold, input bit mid_start);
    logic pop, st;
    init_stats(base);
    base_addr_i = base;
    num_tiles_i = tiles;
    step(mode == 0, 1'b1);
    start_cyc = cyc;
    timed_out = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      pop = (mode == 0) ? 1'b1 : (mode == 1) ? (k >= hold) : k[0];
      st  = mid_start && (k == 10);
      if (st) begin
        base_addr_i = 16'h5555;
        num_tiles_i = 8'd3;
      end
      step(pop, st);
      if (k == 1) err_early = error_o;
      if (mode == 1 && k == hold - 1) begin
        hold_rd    = mem_rd_en_o;
        hold_vld   = weight_fifo_valid_o;
        reads_hold = n_reads;
      end
      if (n_done > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL job_timeout: done_o never seen, base %0h", base); end
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0; start_i = 1'b0; weight_pop_i = 1'b0;
    base_addr_i = '0; num_tiles_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (mem_rd_en_o !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %0b expected 0", mem_rd_en_o); end
    checks++; if (mem_addr_o !== 16'h0) begin errors++; $display("FAIL rst_addr: got %0h expected 0", mem_addr_o); end
    checks++; if (weight_row_o !== '0) begin errors++; $display("FAIL rst_row: got %0h expected 0", weight_row_o); end
    checks++; if (weight_fifo_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", weight_fifo_valid_o); end
    checks++; if (tile_last_row_o !== 1'b0) begin errors++; $display("FAIL rst_last: got %0b expected 0", tile_last_row_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b expected 0", done_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL rst_error: got %0b expected 0", error_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_single_tile();
    run_job(16'h0100, 8'd1, 0, 0, 1'b0);
    checks++; if (n_reads !== 32) begin errors++; $display("FAIL t1_reads: got %0d expected 32", n_reads); end
    checks++; if (addr_err !== 0) begin errors++; $display("FAIL t1_addr_order: got %0d bad expected 0", addr_err); end
    checks++; if (n_rows !== 32) begin errors++; $display("FAIL t1_rows: got %0d expected 32", n_rows); end
    checks++; if (data_err !== 0) begin errors++; $display("FAIL t1_data: got %0d bad expected 0", data_err); end
    checks++; if (last_err !== 0 || n_last !== 1) begin errors++; $display("FAIL t1_last_row: got %0d bad/%0d tags expected 0/1", last_err, n_last); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL t1_done: got %0d pulses expected 1", n_done); end
    checks++; if (done_busy !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL t1_busy: got %0b/%0b expected 0/0", done_busy, busy_o); end
    checks++; if (first_rd !== start_cyc + 1) begin errors++; $display("FAIL t1_rd_latency: got %0d expected %0d", first_rd - start_cyc, 1); end
    checks++; if (first_vld !== start_cyc + 3) begin errors++; $display("FAIL t1_valid_latency: got %0d expected %0d", first_vld - start_cyc, 3); end
    checks++; if (last_pop - first_vld !== 31) begin errors++; $display("FAIL t1_throughput: got %0d expected 31", last_pop - first_vld); end
    checks++; if (done_cyc !== last_pop + 1) begin errors++; $display("FAIL t1_done_timing: got %0d expected %0d", done_cyc, last_pop + 1); end
  endtask

  task automatic test_back_pressure();
    run_job(16'h0400, 8'd2, 1, 20, 1'b0);
    checks++; if (reads_hold !== 4) begin errors++; $display("FAIL t2_reads_held: got %0d expected 4", reads_hold); end
    checks++; if (hold_rd !== 1'b0 || hold_vld !== 1'b1) begin errors++; $display("FAIL t2_hold_state: got rd %0b valid %0b expected 0/1", hold_rd, hold_vld); end
    checks++; if (max_out !== 4) begin errors++; $display("FAIL t2_max_outstanding: got %0d expected 4", max_out); end
    checks++; if (n_reads !== 64 || addr_err !== 0) begin errors++; $display("FAIL t2_reads: got %0d reads %0d bad expected 64/0", n_reads, addr_err); end
    checks++; if (n_rows !== 64 || data_err !== 0) begin errors++; $display("FAIL t2_rows: got %0d rows %0d bad expected 64/0", n_rows, data_err); end
    checks++; if (n_last !== 2 || last_err !== 0) begin errors++; $display("FAIL t2_last_row: got %0d tags %0d bad expected 2/0", n_last, last_err); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL t2_done: got %0d pulses expected 1", n_done); end
  endtask

  task automatic test_toggle_pop();
    run_job(16'h0800, 8'd1, 2, 0, 1'b0);
    checks++; if (max_out > 4) begin errors++; $display("FAIL t3_max_outstanding: got %0d expected <=4", max_out); end
    checks++; if (n_rows !== 32 || data_err !== 0) begin errors++; $display("FAIL t3_rows: got %0d rows %0d bad expected 32/0", n_rows, data_err); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL t3_done: got %0d pulses expected 1", n_done); end
  endtask

  task automatic test_pop_empty();
    apply_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL t4_error_clear: got %0b expected 0", error_o); end
    run_job(16'h0040, 8'd1, 0, 0, 1'b0);
    checks++; if (err_early !== 1'b1) begin errors++; $display("FAIL t4_error_set: got %0b expected 1", err_early); end
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL t4_error_sticky: got %0b expected 1", error_o); end
    checks++; if (n_rows !== 32 || data_err !== 0) begin errors++; $display("FAIL t4_rows: got %0d rows %0d bad expected 32/0", n_rows, data_err); end
  endtask

  task automatic test_addr_wrap();
    run_job(16'hFFF0, 8'd1, 0, 0, 1'b0);
    checks++; if (n_reads !== 32 || addr_err !== 0) begin errors++; $display("FAIL t5_wrap_reads: got %0d reads %0d bad expected 32/0", n_reads, addr_err); end
    checks++; if (rd_q.size() < 17 || rd_q[15] !== 16'hFFFF || rd_q[16] !== 16'h0000) begin errors++; $display("FAIL t5_wrap_point: got %0d reads expected FFFF then 0000 at 15/16", rd_q.size()); end
    checks++; if (data_err !== 0) begin errors++; $display("FAIL t5_wrap_data: got %0d bad expected 0", data_err); end
  endtask

  task automatic test_zero_tiles();
    run_job(16'h1234, 8'd0, 1, 1000, 1'b0);
    checks++; if (n_done !== 1) begin errors++; $display("FAIL t5_zero_done: got %0d pulses expected 1", n_done); end
    checks++; if (done_cyc !== start_cyc + 1) begin errors++; $display("FAIL t5_zero_timing: got %0d expected %0d", done_cyc - start_cyc, 1); end
    checks++; if (n_reads !== 0) begin errors++; $display("FAIL t5_zero_reads: got %0d expected 0", n_reads); end
    checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL t5_zero_busy: got %0b expected 0", done_busy); end
  endtask

  task automatic test_reset_mid_job();
    init_stats(16'h0300);
    base_addr_i = 16'h0300;
    num_tiles_i = 8'd1;
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    checks++; if (n_reads !== 4 || weight_fifo_valid_o !== 1'b1) begin errors++; $display("FAIL t6_prefill: got %0d reads valid %0b expected 4/1", n_reads, weight_fifo_valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (weight_fifo_valid_o !== 1'b0 || weight_row_o !== '0) begin errors++; $display("FAIL t6_async_fifo: got valid %0b row %0h expected 0", weight_fifo_valid_o, weight_row_o); end
    checks++; if (busy_o !== 1'b0 || mem_rd_en_o !== 1'b0) begin errors++; $display("FAIL t6_async_ctrl: got busy %0b rd %0b expected 0/0", busy_o, mem_rd_en_o); end
    checks++; if (error_o !== 1'b0 || tile_last_row_o !== 1'b0) begin errors++; $display("FAIL t6_async_flags: got err %0b last %0b expected 0/0", error_o, tile_last_row_o); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    run_job(16'h0200, 8'd1, 0, 0, 1'b1);
    checks++; if (n_reads !== 32 || addr_err !== 0) begin errors++; $display("FAIL t6_reads: got %0d reads %0d bad expected 32/0", n_reads, addr_err); end
    checks++; if (n_rows !== 32 || data_err !== 0) begin errors++; $display("FAIL t6_rows: got %0d rows %0d bad expected 32/0", n_rows, data_err); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL t6_done: got %0d pulses expected 1", n_done); end
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; weight_pop_i = 1'b0;
    base_addr_i = '0; num_tiles_i = '0;
    test_reset();
    test_single_tile();
    test_back_pressure();
    test_toggle_pop();
    test_pop_empty();
    test_addr_wrap();
    test_zero_tiles();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
